// File: rtl/packet_framer.sv
// Transmit-side packet framer: prepends a header flit to a payload stream and
// meters flits out against downstream buffer credits. Optional: PACKET_FRAMER_SEQ_EN.
module packet_framer #(
  parameter int FLIT_SIZE         = 64,
  parameter int TO_ADDRESS_MSB    = 63,
  parameter int TO_ADDRESS_LSB    = 56,
  parameter int FROM_ADDRESS_MSB  = 55,
  parameter int FROM_ADDRESS_LSB  = 48,
  parameter int PACKET_LENGTH_MSB = 47,
  parameter int PACKET_LENGTH_LSB = 40,
  parameter logic [FROM_ADDRESS_MSB-FROM_ADDRESS_LSB:0] LOCAL_ADDR = '0,
  parameter int CREDITS           = 256
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       cmd_valid,
  output logic                                       cmd_ready,
  input  logic [TO_ADDRESS_MSB-TO_ADDRESS_LSB:0]     cmd_to_addr,
  input  logic [PACKET_LENGTH_MSB-PACKET_LENGTH_LSB:0] cmd_length,
  input  logic [FLIT_SIZE-1:0]                       pay_flit,
  input  logic                                       pay_valid,
  output logic                                       pay_ready,
  output logic [FLIT_SIZE-1:0]                       out_flit,
  output logic                                       out_flit_valid,
  input  logic                                       credit_return,
  output logic [$clog2(CREDITS):0]                   credits,
  output logic                                       busy,
`ifdef PACKET_FRAMER_SEQ_EN
  output logic [7:0]                                 seq_num,
`endif
  output logic                                       err_len
);

  localparam int LEN_W = PACKET_LENGTH_MSB - PACKET_LENGTH_LSB + 1;
  localparam int CW    = $clog2(CREDITS) + 1;

  typedef enum logic [1:0] {IDLE, HEADER, BODY} state_t;

  state_t               state_q;
  logic [CW-1:0]        credits_q, credits_d;
  logic [LEN_W-1:0]     remaining_q;
  logic [FLIT_SIZE-1:0] header_q, header_d;
  logic [FLIT_SIZE-1:0] out_flit_q;
  logic                 out_valid_q;
  logic                 err_len_q;
  logic                 has_credit;
  logic                 cmd_fire;
  logic                 send;
`ifdef PACKET_FRAMER_SEQ_EN
  logic [7:0]           seq_q;
`endif

  always_comb begin
    has_credit = (credits_q != '0);
    cmd_fire   = cmd_valid && (state_q == IDLE);
    send       = has_credit && ((state_q == HEADER) || ((state_q == BODY) && pay_valid));

    // A return arriving with a send cancels out; excess returns at full are dropped.
    credits_d = credits_q;
    if (send && !credit_return) begin
      credits_d = credits_q - 1'b1;
    end else if (!send && credit_return && (credits_q != CW'(CREDITS))) begin
      credits_d = credits_q + 1'b1;
    end

    header_d = '0;
    header_d[TO_ADDRESS_MSB:TO_ADDRESS_LSB]       = cmd_to_addr;
    header_d[FROM_ADDRESS_MSB:FROM_ADDRESS_LSB]   = LOCAL_ADDR;
    header_d[PACKET_LENGTH_MSB:PACKET_LENGTH_LSB] = cmd_length;
`ifdef PACKET_FRAMER_SEQ_EN
    header_d[39:32] = seq_q;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      credits_q   <= CW'(CREDITS);
      remaining_q <= '0;
      header_q    <= '0;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
`ifdef PACKET_FRAMER_SEQ_EN
      seq_q       <= '0;
`endif
    end else begin
      credits_q   <= credits_d;
      out_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_length == '0) begin
              err_len_q <= 1'b1;
            end else begin
              header_q    <= header_d;
              remaining_q <= cmd_length - 1'b1;
              state_q     <= HEADER;
`ifdef PACKET_FRAMER_SEQ_EN
              seq_q       <= seq_q + 1'b1;
`endif
            end
          end
        end
        HEADER: begin
          if (has_credit) begin
            out_flit_q  <= header_q;
            out_valid_q <= 1'b1;
            state_q     <= (remaining_q == '0) ? IDLE : BODY;
          end
        end
        BODY: begin
          if (send) begin
            out_flit_q  <= pay_flit;
            out_valid_q <= 1'b1;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == LEN_W'(1)) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready      = (state_q == IDLE);
  assign pay_ready      = (state_q == BODY) && has_credit;
  assign busy           = (state_q != IDLE);
  assign credits        = credits_q;
  assign out_flit       = out_flit_q;
  assign out_flit_valid = out_valid_q;
  assign err_len        = err_len_q;
`ifdef PACKET_FRAMER_SEQ_EN
  assign seq_num        = seq_q;
`endif

endmodule
